// File: rtl/recirc_oeo_fifo_pkg.sv
// Shared types for the O-E-O recirculation buffer: packet format, request/grant types,
// port count and default depth.
package recirc_oeo_fifo_pkg;

  localparam int OEO_PORTS         = 4;
  localparam int OEO_PORT_W        = $clog2(OEO_PORTS);
  localparam int OEO_DATA_W        = 32;
  localparam int OEO_TS_W          = 16;
  localparam int OEO_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic                  valid;
    logic [OEO_PORT_W-1:0] source;
    logic [OEO_PORT_W-1:0] dest;
    logic [OEO_DATA_W-1:0] data;
    logic [OEO_TS_W-1:0]   timestamp;
  } packet_t;

  typedef logic [OEO_PORTS-1:0] req_t;
  typedef logic                 grant_t;

  function automatic req_t dest_onehot(input logic [OEO_PORT_W-1:0] dest);
    return req_t'(1) << dest;
  endfunction

endpackage

// File: rtl/recirc_oeo_fifo_ram.sv
// Packet storage for the recirculation buffer: one write port, one asynchronous read port.
// Storage is deliberately not reset; occupancy is tracked by the controller.
module recirc_fifo_ram
  import recirc_oeo_fifo_pkg::*;
#(
  parameter  int DEPTH = OEO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  packet_t       i_wdata,
  input  logic [AW-1:0] i_raddr,
  output packet_t       o_rdata
);

  packet_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/recirc_oeo_fifo.sv
// O-E-O recirculation buffer: stores packets diverted out of the switch and re-injects the head
// on allocator grant. Optional statistics (hwm, drop_cnt, bad_grant_cnt) enabled by OEO_STATS_EN.
module recirc_oeo_fifo
  import recirc_oeo_fifo_pkg::*;
#(
  parameter  int DEPTH     = OEO_DEPTH_DEFAULT,
  parameter  int NF_THRESH = DEPTH - 2,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  packet_t i_din,
  input  grant_t  i_grant,
  output packet_t o_dout,
  output req_t    o_req,
  output logic    o_full,
  output logic    o_nearly_full
`ifdef OEO_STATS_EN
  ,
  output logic [CW-1:0] o_hwm,
  output logic [15:0]   o_drop_cnt,
  output logic [15:0]   o_bad_grant_cnt
`endif
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_nearly_full;
  packet_t       r_dout;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  packet_t       w_head;

  recirc_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Push/pop qualify on registered state only; a pop never frees room for a same-cycle push.
  assign w_empty     = (r_count == '0);
  assign w_push      = i_din.valid && !r_full;
  assign w_pop       = i_grant && !w_empty;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_nearly_full <= 1'b0;
      r_dout        <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_dout       <= w_head;
        r_dout.valid <= 1'b1;
      end else begin
        r_dout.valid <= 1'b0;
      end
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == CW'(DEPTH));
      r_nearly_full <= (w_count_nxt >= CW'(NF_THRESH));
    end
  end

  assign o_req         = w_empty ? '0 : dest_onehot(w_head.dest);
  assign o_dout        = r_dout;
  assign o_full        = r_full;
  assign o_nearly_full = r_nearly_full;

`ifdef OEO_STATS_EN
  logic [CW-1:0] r_hwm;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   r_bad_grant_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hwm           <= '0;
      r_drop_cnt      <= '0;
      r_bad_grant_cnt <= '0;
    end else begin
      if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
      if (i_din.valid && r_full && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (i_grant && w_empty && (r_bad_grant_cnt != 16'hFFFF))
        r_bad_grant_cnt <= r_bad_grant_cnt + 16'd1;
    end
  end

  assign o_hwm           = r_hwm;
  assign o_drop_cnt      = r_drop_cnt;
  assign o_bad_grant_cnt = r_bad_grant_cnt;
`endif

endmodule

// File: tb/tb_recirc_oeo_fifo.sv
// Directed self-checking bench for recirc_oeo_fifo (DEPTH=16); statistics checked when
// OEO_STATS_EN is defined.
module tb_recirc_oeo_fifo;
  import recirc_oeo_fifo_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  packet_t din;
  grant_t  grant;
  packet_t dout;
  req_t    req;
  logic    full;
  logic    nearly_full;
`ifdef OEO_STATS_EN
  logic [4:0]  hwm;
  logic [15:0] drop_cnt;
  logic [15:0] bad_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  recirc_oeo_fifo dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_din         (din),
    .i_grant       (grant),
    .o_dout        (dout),
    .o_req         (req),
    .o_full        (full),
    .o_nearly_full (nearly_full)
`ifdef OEO_STATS_EN
    ,
    .o_hwm           (hwm),
    .o_drop_cnt      (drop_cnt),
    .o_bad_grant_cnt (bad_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic v, input logic [1:0] dest, input logic [31:0] data);
    din.valid     = v;
    din.source    = 2'd1;
    din.dest      = dest;
    din.data      = data;
    din.timestamp = data[15:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    grant = 1'b0;
    set_din(1'b0, 2'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL reset_req got %b exp 0000", req); end
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout.valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (nearly_full !== 1'b0) begin errors++; $display("FAIL reset_nf got %b exp 0", nearly_full); end
  endtask

  task automatic test_single();
    set_din(1'b1, 2'd3, 32'hCAFE_0003);
    tick();
    set_din(1'b0, 2'd0, 32'd0);
    checks++; if (req !== 4'b1000) begin errors++; $display("FAIL single_req got %b exp 1000", req); end
    tick();
    tick();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    checks++; if (dout.valid !== 1'b1) begin errors++; $display("FAIL single_dout_valid got %b exp 1", dout.valid); end
    checks++; if (dout.dest !== 2'd3) begin errors++; $display("FAIL single_dout_dest got %0d exp 3", dout.dest); end
    checks++; if (dout.data !== 32'hCAFE_0003) begin errors++; $display("FAIL single_dout_data got %h exp cafe0003", dout.data); end
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL single_req_after got %b exp 0000", req); end
    tick();
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL single_dout_drop got %b exp 0", dout.valid); end
  endtask

  task automatic test_fill();
    req_t exp_req;
    for (int i = 0; i < 16; i++) begin
      set_din(1'b1, 2'(i % 4), 32'h100 + 32'(i));
      tick();
      checks++; if (nearly_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_nf[%0d] got %b exp %b", i, nearly_full, (i + 1 >= 14)); end
      checks++; if (full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i + 1 == 16)); end
    end
    set_din(1'b1, 2'd2, 32'hDEAD);
    tick();
    set_din(1'b0, 2'd0, 32'd0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL drop_full got %b exp 1", full); end
`ifdef OEO_STATS_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
    checks++; if (hwm !== 5'd16) begin errors++; $display("FAIL hwm got %0d exp 16", hwm); end
`endif
    grant = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_req = '0;
      exp_req[i % 4] = 1'b1;
      checks++; if (req !== exp_req) begin errors++; $display("FAIL drain_req[%0d] got %b exp %b", i, req, exp_req); end
      tick();
      checks++; if (dout.valid !== 1'b1 || dout.data !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL drain_data[%0d] got v=%b %h exp v=1 %h", i, dout.valid, dout.data, 32'h100 + 32'(i));
      end
    end
    grant = 1'b0;
    checks++; if (full !== 1'b0 || nearly_full !== 1'b0) begin errors++; $display("FAIL drain_flags got full=%b nf=%b exp 0 0", full, nearly_full); end
    tick();
    checks++; if (dout.valid !== 1'b0 || req !== 4'b0000) begin errors++; $display("FAIL drain_empty got v=%b req=%b exp 0 0000", dout.valid, req); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      set_din(1'b1, 2'(i % 4), 32'h200 + 32'(i));
      tick();
    end
    grant = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_din(1'b1, 2'((k + 8) % 4), 32'h200 + 32'(k + 8));
      tick();
      checks++; if (dout.valid !== 1'b1 || dout.data !== 32'h200 + 32'(k)) begin
        errors++; $display("FAIL stream[%0d] got v=%b %h exp v=1 %h", k, dout.valid, dout.data, 32'h200 + 32'(k));
      end
      checks++; if (full !== 1'b0 || nearly_full !== 1'b0) begin errors++; $display("FAIL stream_flags[%0d] got full=%b nf=%b exp 0 0", k, full, nearly_full); end
    end
    set_din(1'b0, 2'd0, 32'd0);
    for (int k = 20; k < 28; k++) begin
      tick();
      checks++; if (dout.valid !== 1'b1 || dout.data !== 32'h200 + 32'(k)) begin
        errors++; $display("FAIL stream_tail[%0d] got v=%b %h exp v=1 %h", k, dout.valid, dout.data, 32'h200 + 32'(k));
      end
    end
    grant = 1'b0;
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL stream_empty_req got %b exp 0000", req); end
    tick();
  endtask

  task automatic test_empty_grant();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL bad_grant_dout got %b exp 0", dout.valid); end
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL bad_grant_req got %b exp 0000", req); end
`ifdef OEO_STATS_EN
    checks++; if (bad_grant_cnt !== 16'd1) begin errors++; $display("FAIL bad_grant_cnt got %0d exp 1", bad_grant_cnt); end
`endif
    set_din(1'b1, 2'd1, 32'h5151);
    grant = 1'b1;
    tick();
    set_din(1'b0, 2'd0, 32'd0);
    grant = 1'b0;
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL pushgrant_dout got %b exp 0", dout.valid); end
    checks++; if (req !== 4'b0010) begin errors++; $display("FAIL pushgrant_req got %b exp 0010", req); end
    grant = 1'b1;
    tick();
    grant = 1'b0;
    checks++; if (dout.valid !== 1'b1 || dout.data !== 32'h5151) begin errors++; $display("FAIL pushgrant_data got v=%b %h exp v=1 5151", dout.valid, dout.data); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      set_din(1'b1, 2'(i % 4), 32'h300 + 32'(i));
      tick();
    end
    set_din(1'b0, 2'd0, 32'd0);
    grant = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grant = 1'b0;
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL rstmid_req got %b exp 0000", req); end
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL rstmid_dout got %b exp 0", dout.valid); end
    checks++; if (full !== 1'b0 || nearly_full !== 1'b0) begin errors++; $display("FAIL rstmid_flags got full=%b nf=%b exp 0 0", full, nearly_full); end
`ifdef OEO_STATS_EN
    checks++; if (drop_cnt !== 16'd0 || bad_grant_cnt !== 16'd0 || hwm !== 5'd0) begin
      errors++; $display("FAIL rstmid_stats got drop=%0d bad=%0d hwm=%0d exp 0 0 0", drop_cnt, bad_grant_cnt, hwm);
    end
`endif
    set_din(1'b1, 2'd2, 32'h777);
    tick();
    set_din(1'b0, 2'd0, 32'd0);
    checks++; if (req !== 4'b0100) begin errors++; $display("FAIL rstmid_fresh_req got %b exp 0100", req); end
    grant = 1'b1;
    tick();
    grant = 1'b0;
    checks++; if (dout.valid !== 1'b1 || dout.data !== 32'h777) begin errors++; $display("FAIL rstmid_fresh_data got v=%b %h exp v=1 777", dout.valid, dout.data); end
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL rstmid_final_req got %b exp 0000", req); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_empty_grant();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
